// File: rtl/fabric_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fabric_cfg_pkg
// Purpose  : Shared configuration-fabric constants (tile chain lengths) and
//            the state encoding of the configuration shift driver.
// Revision : 1.0 - initial release
// ============================================================================
package fabric_cfg_pkg;

    // Configuration chain contributions of one mac_tile, in bits
    localparam int DCB_CONF_WIDTH  = 3072;
    localparam int DSB_CONF_WIDTH  = 780;
    localparam int MAC_CONF_WIDTH  = 131;
    localparam int TILE_CONF_WIDTH = DCB_CONF_WIDTH + DSB_CONF_WIDTH + MAC_CONF_WIDTH;

    // Load sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

endpackage : fabric_cfg_pkg
`default_nettype wire

// File: rtl/cfg_shift_driver.sv
`default_nettype none
// ============================================================================
// Module   : cfg_shift_driver
// Purpose  : Serialises a word stream (LSB first) onto a tile configuration
//            scan chain: exactly CONF_WIDTH enabled shift cycles, then a
//            one-cycle cset commit strobe and a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_shift_driver
    import fabric_cfg_pkg::*;
#(
    parameter int CONF_WIDTH = TILE_CONF_WIDTH,
    parameter int WORD_W     = 32,
    parameter int CNT_W      = $clog2(CONF_WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              shift_out,
    output logic              cen,
    output logic              cset,
    output logic              busy,
    output logic              done
);

    localparam int c_IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int c_NWORDS = (CONF_WIDTH + WORD_W - 1) / WORD_W;
    localparam int c_WCNT_W = $clog2(c_NWORDS + 1);

    localparam logic [c_IDX_W-1:0]  c_IDX_LAST = c_IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]    c_CNT_LAST = CNT_W'(CONF_WIDTH - 1);
    localparam logic [c_WCNT_W-1:0] c_WORDS    = c_WCNT_W'(c_NWORDS);

    // r_buf[0] is the bit currently on shift_out; r_valid marks it as live
    cfg_state_t          r_state,  w_state;
    logic [WORD_W-1:0]   r_buf,    w_buf;
    logic                r_valid,  w_valid;
    logic [c_IDX_W-1:0]  r_idx,    w_idx;
    logic [CNT_W-1:0]    r_cnt,    w_cnt;
    logic [c_WCNT_W-1:0] r_words,  w_words;
    logic                r_ready,  w_ready;
    logic                r_cset;
    logic                r_busy;
    logic                r_done;

    logic w_accept;
    logic w_last;

    assign w_accept = r_ready & s_valid;
    // The displayed bit is the last one of its word, or the last of the load
    assign w_last   = (r_idx == c_IDX_LAST) || (r_cnt == c_CNT_LAST);

    // Next-state logic: sequencing, shifting, word intake and ready lookahead
    always_comb begin
        w_state = r_state;
        w_buf   = r_buf;
        w_valid = r_valid;
        w_idx   = r_idx;
        w_cnt   = r_cnt;
        w_words = r_words;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state = SHIFT;
                    w_buf   = '0;
                    w_valid = 1'b0;
                    w_idx   = '0;
                    w_cnt   = '0;
                    w_words = '0;
                end
            end
            SHIFT: begin
                if (r_valid) begin
                    w_buf = r_buf >> 1;
                    w_idx = r_idx + 1'b1;
                    w_cnt = r_cnt + 1'b1;
                    // Word exhausted; upper bits of a short final word are dropped here
                    if (w_last) begin
                        w_valid = 1'b0;
                        w_buf   = '0;
                    end
                    if (r_cnt == c_CNT_LAST) begin
                        w_state = COMMIT;
                    end
                end
                // A new word replaces the one whose last bit is on the chain now
                if (w_accept) begin
                    w_buf   = s_data;
                    w_valid = 1'b1;
                    w_idx   = '0;
                    w_words = r_words + 1'b1;
                end
            end
            COMMIT: begin
                w_state = IDLE;
                w_idx   = '0;
                w_cnt   = '0;
                w_words = '0;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
        // Ready for the coming cycle: more words owed and buffer free by its end
        w_ready = (w_state == SHIFT) && (w_words != c_WORDS) &&
                  (!w_valid || (w_idx == c_IDX_LAST) || (w_cnt == c_CNT_LAST));
    end

    // State and registered outputs; reset abandons any partial load without commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_buf   <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_words <= '0;
            r_ready <= 1'b0;
            r_cset  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_buf   <= w_buf;
            r_valid <= w_valid;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_words <= w_words;
            r_ready <= w_ready;
            r_cset  <= (w_state == COMMIT);
            r_busy  <= (w_state != IDLE);
            r_done  <= (r_state == COMMIT);
        end
    end

    assign s_ready   = r_ready;
    assign shift_out = r_buf[0];
    assign cen       = r_valid;
    assign cset      = r_cset;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule : cfg_shift_driver
`default_nettype wire

// File: tb/tb_cfg_shift_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_shift_driver
// Purpose  : Self-checking bench for cfg_shift_driver with a bit scoreboard;
//            one instance with CONF_WIDTH=70 and one with CONF_WIDTH=64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_shift_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic        s_valid;
    logic [31:0] s_data;

    logic a_ready, a_so, a_cen, a_cset, a_busy, a_done;
    logic b_ready, b_so, b_cen, b_cset, b_busy, b_done;

    bit   sel;
    logic o_ready, o_so, o_cen, o_cset, o_busy, o_done;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    cfg_shift_driver #(.CONF_WIDTH(70), .WORD_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .s_data(s_data), .s_valid(s_valid),
        .s_ready(a_ready), .shift_out(a_so), .cen(a_cen), .cset(a_cset),
        .busy(a_busy), .done(a_done)
    );

    cfg_shift_driver #(.CONF_WIDTH(64), .WORD_W(32)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .s_data(s_data), .s_valid(s_valid),
        .s_ready(b_ready), .shift_out(b_so), .cen(b_cen), .cset(b_cset),
        .busy(b_busy), .done(b_done)
    );

    assign o_ready = sel ? b_ready : a_ready;
    assign o_so    = sel ? b_so    : a_so;
    assign o_cen   = sel ? b_cen   : a_cen;
    assign o_cset  = sel ? b_cset  : a_cset;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_done  = sel ? b_done  : a_done;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One load on the selected instance; gap = idle cycles after each word,
    // start_at / rst_at = bit count at which to pulse start / rst (-1 = never)
    task automatic run_load(input bit s, input int gap, input int start_at, input int rst_at);
        int cw, nwords, words, pushed, cen_cnt, cset_cnt, first_cen, last_cen;
        int idle, rst_wait, rst_tail, done_cyc, used;
        bit fin, prev_cen, prev_cset, hs, mid_pulsed, rst_fired, pulse_now, rst_now;
        cw = s ? 64 : 70;
        nwords = (cw + 31) / 32;
        words = 0; pushed = 0; cen_cnt = 0; cset_cnt = 0; first_cen = -1; last_cen = -1;
        idle = 0; rst_wait = 0; rst_tail = 0; done_cyc = -1; used = 0;
        fin = 0; prev_cen = 0; prev_cset = 0; hs = 0; mid_pulsed = 0; rst_fired = 0;
        pulse_now = 0; rst_now = 0;
        sel = s;
        exp_q.delete();
        @(posedge clk); #1;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        s_valid = 1'b1;
        s_data  = $urandom;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check("busy_at_t1", o_busy, 1);
                check("ready_at_t1", o_ready, 1);
            end
            if (o_cen) begin
                check("cen_has_expected_bit", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("shift_bit", o_so, exp_q.pop_front());
                if (first_cen < 0) first_cen = cyc;
                last_cen = cyc;
                cen_cnt++;
            end
            if (o_cset) begin
                cset_cnt++;
                check("cset_follows_last_bit", prev_cen, 1);
                check("cset_without_cen", o_cen, 0);
                check("queue_empty_at_cset", exp_q.size(), 0);
                check("busy_at_cset", o_busy, 1);
            end
            if (o_done) begin
                check("done_follows_cset", prev_cset, 1);
                check("busy_low_at_done", o_busy, 0);
                done_cyc = cyc;
                fin = 1;
            end
            if (words == nwords) check("no_ready_after_last_word", o_ready, 0);
            hs = s_valid && o_ready;
            if (hs) begin
                used = (cw - pushed < 32) ? (cw - pushed) : 32;
                for (int i = 0; i < used; i++) exp_q.push_back(s_data[i]);
                pushed += used;
                words++;
            end
            if (rst_tail > 0) begin
                rst_tail--;
                if (rst_tail == 0) fin = 1;
            end
            if (rst_wait > 0) begin
                rst_wait--;
                if (rst_wait == 0) begin
                    check("rst_ready", o_ready, 0);
                    check("rst_shift_out", o_so, 0);
                    check("rst_cen", o_cen, 0);
                    check("rst_cset", o_cset, 0);
                    check("rst_busy", o_busy, 0);
                    check("rst_done", o_done, 0);
                    exp_q.delete();
                    rst_tail = 4;
                end
            end
            if (start_at >= 0 && cen_cnt == start_at && !mid_pulsed) begin
                mid_pulsed = 1;
                pulse_now  = 1;
            end
            if (rst_at >= 0 && cen_cnt == rst_at && !rst_fired) begin
                rst_fired = 1;
                rst_now   = 1;
            end
            prev_cen  = o_cen;
            prev_cset = o_cset;
            @(posedge clk); #1;
            start_a = 1'b0;
            start_b = 1'b0;
            rst     = 1'b0;
            if (pulse_now) begin
                if (s) start_b = 1'b1; else start_a = 1'b1;
                pulse_now = 0;
            end
            if (rst_now) begin
                rst      = 1'b1;
                rst_now  = 0;
                rst_wait = 2;
            end
            if (hs) begin
                s_data = $urandom;
                if (gap > 0) begin
                    s_valid = 1'b0;
                    idle    = gap;
                end
            end else if (idle > 0) begin
                idle--;
                if (idle == 0) s_valid = 1'b1;
            end
        end
        check("load_terminated", fin, 1);
        if (rst_at < 0) begin
            check("cen_count", cen_cnt, cw);
            check("cset_count", cset_cnt, 1);
            check("words_accepted", words, nwords);
            if (gap == 0) begin
                check("cen_contiguous", last_cen - first_cen + 1, cw);
                check("start_to_done", done_cyc, cw + 3);
            end
        end else begin
            check("no_cset_after_rst", cset_cnt, 0);
        end
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        sel     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", a_ready, 0);
        check("reset_shift_out", a_so, 0);
        check("reset_cen", a_cen, 0);
        check("reset_cset", a_cset, 0);
        check("reset_busy", a_busy, 0);
        check("reset_done", a_done, 0);
        check("reset_b_busy", b_busy, 0);
        check("reset_b_ready", b_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_load(1'b0, 0, -1, -1);   // full load, valid held
        run_load(1'b0, 5, -1, -1);   // starved source
        run_load(1'b0, 0, 40, -1);   // start while busy
        run_load(1'b0, 0, -1, 50);   // reset mid-load
        run_load(1'b0, 0, -1, -1);   // clean load after reset
        run_load(1'b1, 0, -1, -1);   // exact multiple of word width
        run_load(1'b1, 3, -1, -1);   // exact multiple, starved

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cfg_shift_driver
`default_nettype wire
